// File: rtl/bit_sync_filter_if.sv
// Channel bundle for bit_sync_filter: raw asynchronous inputs, the clean
// level/edge/event outputs and the write-one-to-clear strobe.
interface bit_sync_filter_if #(
   parameter int BUS_WIDTH = 4
);
   logic [BUS_WIDTH-1:0] ASYNC;
   logic [BUS_WIDTH-1:0] EVENT_CLR;
   logic [BUS_WIDTH-1:0] SYNC;
   logic [BUS_WIDTH-1:0] RISE;
   logic [BUS_WIDTH-1:0] FALL;
   logic [BUS_WIDTH-1:0] EVENT;

   modport master (
      output ASYNC, EVENT_CLR,
      input  SYNC, RISE, FALL, EVENT
   );

   modport slave (
      input  ASYNC, EVENT_CLR,
      output SYNC, RISE, FALL, EVENT
   );
endinterface

// File: rtl/bit_sync_filter.sv
// Per-channel flip-flop synchroniser followed by a persistence filter that
// produces a clean level, registered rise/fall pulses and a sticky event flag.
module bit_sync_filter #(
   parameter int                   NUM_STAGES    = 2,
   parameter int                   BUS_WIDTH     = 4,
   parameter int                   FILTER_CYCLES = 4,
   parameter logic [BUS_WIDTH-1:0] RST_VAL       = '0
) (
   input logic              CLK,
   input logic              RST,
   bit_sync_filter_if.slave bus
);

   localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

   logic [BUS_WIDTH-1:0] chain_p [NUM_STAGES];
   logic [BUS_WIDTH-1:0] raw;
   logic [BUS_WIDTH-1:0] sync_p1;
   logic [BUS_WIDTH-1:0] rise_p1;
   logic [BUS_WIDTH-1:0] fall_p1;
   logic [BUS_WIDTH-1:0] event_p2;
   logic [CNT_W-1:0]     cnt [BUS_WIDTH];

   // Synchroniser chain: no logic between stages
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int k = 0; k < NUM_STAGES; k++) chain_p[k] <= RST_VAL;
      end else begin
         chain_p[0] <= bus.ASYNC;
         for (int k = 1; k < NUM_STAGES; k++) chain_p[k] <= chain_p[k-1];
      end
   end

   assign raw = chain_p[NUM_STAGES-1];

   // Filter stage: a change is accepted only after FILTER_CYCLES consecutive mismatches
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_p1 <= RST_VAL;
         rise_p1 <= '0;
         fall_p1 <= '0;
         for (int i = 0; i < BUS_WIDTH; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < BUS_WIDTH; i++) begin
            rise_p1[i] <= 1'b0;
            fall_p1[i] <= 1'b0;
            if (raw[i] == sync_p1[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               sync_p1[i] <= raw[i];
               rise_p1[i] <= raw[i];
               fall_p1[i] <= ~raw[i];
               cnt[i]     <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // Event stage: set has priority over the write-one-to-clear strobe
   always_ff @(posedge CLK) begin
      if (RST) begin
         event_p2 <= '0;
      end else begin
         event_p2 <= rise_p1 | fall_p1 | (event_p2 & ~bus.EVENT_CLR);
      end
   end

   assign bus.SYNC  = sync_p1;
   assign bus.RISE  = rise_p1;
   assign bus.FALL  = fall_p1;
   assign bus.EVENT = event_p2;

endmodule
